// File: rtl/ssd_scan_driver.sv
// Scans active-high seven-segment patterns onto active-low anode/cathode pins, one digit per slot.
// Each slot starts with a blanking interval. New data is held back and applied only at the frame wrap.
module ssd_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7*NUM_DIGITS-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic                    pending,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    frame_tick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SLOT_END  = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_DIGITS - 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   logic [0:0]              state, state_nx;
   logic [CW-1:0]           cnt, cnt_nx;
   logic [IW-1:0]           idx, idx_nx;
   logic                    wrap;
   logic [7*NUM_DIGITS-1:0] shadow_seg, shadow_seg_nx, staged_seg;
   logic [NUM_DIGITS-1:0]   shadow_en, shadow_en_nx, staged_en;
   logic [6:0]              pattern;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   an_nx;
   logic [6:0]              seg_nx;

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt + 1'b1;
      wrap     = 1'b0;
      if (state == ST_BLANK) begin
         if (cnt == CNT_BLANK_END) state_nx = ST_SHOW;
      end else if (cnt == CNT_SLOT_END) begin
         state_nx = ST_BLANK;
         cnt_nx   = '0;
         wrap     = (idx == IDX_LAST);
         idx_nx   = wrap ? '0 : idx + 1'b1;
      end
   end

   // frame_tick marks the boundary cycle itself, so it gates the shadow update
   always_comb begin
      shadow_seg_nx = shadow_seg;
      shadow_en_nx  = shadow_en;
      if (frame_tick) begin
         if (load) begin
            shadow_seg_nx = seg_in;
            shadow_en_nx  = digit_en;
         end else if (pending) begin
            shadow_seg_nx = staged_seg;
            shadow_en_nx  = staged_en;
         end
      end
   end

   // Outputs are derived from next-cycle state so they line up with the state they describe
   always_comb begin
      pattern = '0;
      lit     = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_nx == IW'(i)) begin
            pattern = shadow_seg_nx[7*i +: 7];
            lit     = shadow_en_nx[i];
         end
      end
      lit    = lit && (state_nx == ST_SHOW);
      an_nx  = '1;
      seg_nx = '1;
      if (lit) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            an_nx[i] = (idx_nx != IW'(i));
         end
         seg_nx = ~pattern;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BLANK;
         cnt        <= '0;
         idx        <= '0;
         frame_tick <= 1'b0;
         an         <= '1;
         seg        <= 7'h7F;
         shadow_seg <= '0;
         shadow_en  <= '0;
         staged_seg <= '0;
         staged_en  <= '0;
         pending    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         frame_tick <= wrap;
         an         <= an_nx;
         seg        <= seg_nx;
         shadow_seg <= shadow_seg_nx;
         shadow_en  <= shadow_en_nx;
         if (frame_tick) begin
            pending <= 1'b0;
         end else if (load) begin
            staged_seg <= seg_in;
            staged_en  <= digit_en;
            pending    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver (2 digits, 8-cycle slots, 2 blank cycles).
// Expected outputs come from slot arithmetic on the cycle number plus a staged/shadow data model.
module tb_ssd_scan_driver;

   localparam int ND = 2;
   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FP = ND * RD;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7*ND-1:0] seg_in = '0;
   logic [ND-1:0]   digit_en = '0;
   logic            load = 1'b0;
   logic            pending;
   logic [ND-1:0]   an;
   logic [6:0]      seg;
   logic            frame_tick;

   ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .digit_en(digit_en), .load(load),
      .pending(pending), .an(an), .seg(seg), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int t     = 0;

   logic [7*ND-1:0] m_seg, m_st_seg;
   logic [ND-1:0]   m_en, m_st_en;
   logic            m_pending;

   function automatic logic [10:0] exp_vec();
      int pos = t % RD;
      int d   = (t / RD) % ND;
      logic [1:0] a = 2'b11;
      logic [6:0] s = 7'h7F;
      logic tick = (t > 0) && (t % FP == 0);
      if (pos >= BC && m_en[d]) begin
         a = ~(2'b01 << d);
         s = ~m_seg[7*d +: 7];
      end
      return {a, s, tick, m_pending};
   endfunction

   task automatic do_reset();
      load = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t = 0;
      m_seg = '0; m_en = '0; m_st_seg = '0; m_st_en = '0; m_pending = 1'b0;
   endtask

   // Drives one cycle's inputs and advances the data model to the next cycle
   task automatic cyc(input logic ld, input logic [7*ND-1:0] s, input logic [ND-1:0] e);
      load = ld; seg_in = s; digit_en = e;
      if (t > 0 && t % FP == 0) begin
         if (ld) begin
            m_seg = s; m_en = e;
         end else if (m_pending) begin
            m_seg = m_st_seg; m_en = m_st_en;
         end
         m_pending = 1'b0;
      end else if (ld) begin
         m_st_seg = s; m_st_en = e; m_pending = 1'b1;
      end
      @(negedge clk);
      t++;
   endtask

   task automatic test_reset();
      logic [10:0] obs;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      obs = {an, seg, frame_tick, pending};
      total++;
      if (obs !== {2'b11, 7'h7F, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_hold got=%h exp=%h", obs, {2'b11, 7'h7F, 1'b0, 1'b0});
      end
      do_reset();
      obs = {an, seg, frame_tick, pending};
      total++;
      if (obs !== exp_vec()) begin
         bad++; $display("FAIL reset_exit got=%h exp=%h", obs, exp_vec());
      end
   endtask

   task automatic test_idle();
      logic [10:0] obs;
      int ticks = 0;
      do_reset();
      while (t < 40) begin
         obs = {an, seg, frame_tick, pending};
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL idle t=%0d got=%h exp=%h", t, obs, exp_vec());
         end
         if (frame_tick === 1'b1) ticks++;
         cyc(1'b0, '0, '0);
      end
      total++;
      if (ticks != 2) begin
         bad++; $display("FAIL idle_ticks got=%0d exp=2", ticks);
      end
   endtask

   task automatic test_directed();
      logic [10:0] obs;
      do_reset();
      while (t < 64) begin
         obs = {an, seg, frame_tick, pending};
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL directed t=%0d got=%h exp=%h", t, obs, exp_vec());
         end
         if (t == 20 || t == 28 || t == 52 || t == 60) begin
            total++;
            if ((t == 20 && {an, seg} !== {2'b10, 7'h40}) || (t == 28 && {an, seg} !== {2'b01, 7'h79}) ||
                (t == 52 && {an, seg} !== {2'b10, 7'h24}) || (t == 60 && {an, seg} !== {2'b11, 7'h7F})) begin
               bad++; $display("FAIL directed_spot t=%0d got an=%b seg=%h", t, an, seg);
            end
         end
         if (t == 3)       cyc(1'b1, {7'h06, 7'h3F}, 2'b11);
         else if (t == 35) cyc(1'b1, {7'h3F, 7'h5B}, 2'b01);
         else              cyc(1'b0, '0, '0);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] obs;
      do_reset();
      while (t < 48) begin
         obs = {an, seg, frame_tick, pending};
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL b2b t=%0d got=%h exp=%h", t, obs, exp_vec());
         end
         if (t == 20 || t == 36) begin
            total++;
            if ((t == 20 && seg !== 7'h7D) || (t == 36 && seg !== 7'h00)) begin
               bad++; $display("FAIL b2b_spot t=%0d got seg=%h", t, seg);
            end
         end
         case (t)
            5:       cyc(1'b1, {7'h11, 7'h01}, 2'b11);
            9:       cyc(1'b1, {7'h22, 7'h02}, 2'b11);
            20:      cyc(1'b1, {7'h33, 7'h03}, 2'b11);
            32:      cyc(1'b1, {7'h44, 7'h7F}, 2'b11);
            default: cyc(1'b0, '0, '0);
         endcase
      end
   endtask

   task automatic test_mid_reset();
      logic [10:0] obs;
      do_reset();
      while (t < 20) begin
         if (t == 3)       cyc(1'b1, {7'h06, 7'h3F}, 2'b11);
         else if (t == 18) cyc(1'b1, {7'h7F, 7'h7F}, 2'b11);
         else              cyc(1'b0, '0, '0);
      end
      rst = 1'b1;
      cyc(1'b0, '0, '0);
      rst = 1'b0;
      do_reset_model();
      while (t < 40) begin
         obs = {an, seg, frame_tick, pending};
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL mid_reset t=%0d got=%h exp=%h", t, obs, exp_vec());
         end
         cyc(1'b0, '0, '0);
      end
   endtask

   task automatic do_reset_model();
      t = 0;
      m_seg = '0; m_en = '0; m_st_seg = '0; m_st_en = '0; m_pending = 1'b0;
   endtask

   task automatic test_random();
      logic [10:0] obs;
      logic ld;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         obs = {an, seg, frame_tick, pending};
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL random n=%0d t=%0d got=%h exp=%h", n, t, obs, exp_vec());
         end
         if (n == 211) begin
            rst = 1'b1;
            cyc(1'b1, 14'($urandom), 2'($urandom));
            rst = 1'b0;
            do_reset_model();
         end else begin
            ld = ($urandom_range(0, 5) == 0) || (t % FP == 0 && $urandom_range(0, 1) == 1);
            cyc(ld, 14'($urandom), 2'($urandom));
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_directed();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
